core_wb_arb: RTL and testbench

- Writeback arbiter that sits directly upstream of the core register file and drives its single write port (we3/a3/wd3).
- Merges two result sources:
  - the in-order pipeline writeback, which has priority;
  - a long-latency unit (mul/div, load miss) through a valid/ready handshake and a small result FIFO.
- Exports a pending-destination mask to the hazard unit and a stall request that guarantees FIFO drain.

---
 rtl/core_wb_arb_if.sv | 36 +++
 rtl/core_wb_arb.sv | 134 +++++++++++++
 tb/tb_core_wb_arb.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/core_wb_arb_if.sv
// Writeback arbiter bus: pipeline writeback, long-latency result handshake and register-file port.
// Latency: pure signal bundle, no storage.
// Backpressure: o_wb_lu_ready throttles the long-latency source; o_wb_stall holds the pipeline.
interface core_wb_arb_if;
    logic        i_wb_pipe_we;
    logic [4:0]  i_wb_pipe_rd;
    logic [63:0] i_wb_pipe_data;
    logic        i_wb_lu_valid;
    logic        o_wb_lu_ready;
    logic [4:0]  i_wb_lu_rd;
    logic [63:0] i_wb_lu_data;
    logic        o_wb_rf_we;
    logic [4:0]  o_wb_rf_a3;
    logic [63:0] o_wb_rf_wd3;
    logic [31:0] o_wb_busy_mask;
    logic        o_wb_stall;
    logic        o_wb_err;

    // Arbiter side.
    modport slave (
        input  i_wb_pipe_we, i_wb_pipe_rd, i_wb_pipe_data,
        input  i_wb_lu_valid, i_wb_lu_rd, i_wb_lu_data,
        output o_wb_lu_ready,
        output o_wb_rf_we, o_wb_rf_a3, o_wb_rf_wd3,
        output o_wb_busy_mask, o_wb_stall, o_wb_err
    );

    // Core / result-source side.
    modport master (
        output i_wb_pipe_we, i_wb_pipe_rd, i_wb_pipe_data,
        output i_wb_lu_valid, i_wb_lu_rd, i_wb_lu_data,
        input  o_wb_lu_ready,
        input  o_wb_rf_we, o_wb_rf_a3, o_wb_rf_wd3,
        input  o_wb_busy_mask, o_wb_stall, o_wb_err
    );
endinterface

// File: rtl/core_wb_arb.sv
// Register-file write-port arbiter: pipeline writeback first, long-latency results via a small FIFO.
// Latency: pipeline writes pass through combinationally; a queued result can write the cycle after enqueue.
// Backpressure: lu_ready drops when the FIFO is full; stall steals one pipeline slot after STARVE_MAX idle cycles.
module core_wb_arb #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic           i_wb_clk,
    input  logic           i_wb_rst_n,
    core_wb_arb_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]       fifo_rd  [DEPTH];
    logic [63:0]      fifo_dat [DEPTH];
    logic [DEPTH-1:0] slot_vld;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [SW-1:0]    starve;
    logic             err;

    logic        not_empty;
    logic        lu_ready;
    logic        stall;
    logic        pipe_eff;
    logic        enq;
    logic        deq;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [63:0] rf_wd3;
    logic [31:0] busy;

    // Ready and stall come only from registered state, so lu_valid never reaches them.
    assign not_empty = (count != '0);
    assign lu_ready  = (count != CW'(DEPTH));
    assign stall     = (starve == SW'(STARVE_MAX)) & not_empty;

    // The pipeline owns the port unless it writes x0, is idle, or is being held for a FIFO drain.
    // The port is kept quiet while reset is asserted even if the pipeline presents a write.
    assign pipe_eff = i_wb_rst_n & bus.i_wb_pipe_we & (bus.i_wb_pipe_rd != 5'd0) & ~stall;
    assign deq      = i_wb_rst_n & ~pipe_eff & not_empty;
    // Writes to x0 complete the handshake but are never stored.
    assign enq      = bus.i_wb_lu_valid & lu_ready & (bus.i_wb_lu_rd != 5'd0);

    // Register-file port mux; the register file samples on the falling edge.
    always_comb begin
        rf_we  = 1'b0;
        rf_a3  = 5'd0;
        rf_wd3 = 64'd0;
        if (pipe_eff) begin
            rf_we  = 1'b1;
            rf_a3  = bus.i_wb_pipe_rd;
            rf_wd3 = bus.i_wb_pipe_data;
        end else if (deq) begin
            rf_we  = 1'b1;
            rf_a3  = fifo_rd[rd_ptr];
            rf_wd3 = fifo_dat[rd_ptr];
        end
    end

    // Busy mask: OR of one-hot destinations over occupied slots, so duplicates hold the bit until the last drains.
    always_comb begin
        busy = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_vld[i]) begin
                busy[fifo_rd[i]] = 1'b1;
            end
        end
        busy[0] = 1'b0;
    end

    // FIFO control: pointers, occupancy count and per-slot valid bits.
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            slot_vld <= '0;
        end else begin
            if (deq) begin
                rd_ptr           <= rd_ptr + PW'(1);
                slot_vld[rd_ptr] <= 1'b0;
            end
            if (enq) begin
                wr_ptr           <= wr_ptr + PW'(1);
                slot_vld[wr_ptr] <= 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO payload storage; contents are meaningless unless the slot is valid, so no reset is needed.
    always_ff @(posedge i_wb_clk) begin
        if (enq) begin
            fifo_rd[wr_ptr]  <= bus.i_wb_lu_rd;
            fifo_dat[wr_ptr] <= bus.i_wb_lu_data;
        end
    end

    // Starvation counter: counts cycles a non-empty FIFO is denied the port, saturating at STARVE_MAX.
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            starve <= '0;
        end else if (!not_empty || deq) begin
            starve <= '0;
        end else if (starve != SW'(STARVE_MAX)) begin
            starve <= starve + SW'(1);
        end
    end

    // Sticky ordering error: the pipeline overwrote a register that still has a queued result.
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            err <= 1'b0;
        end else if (pipe_eff && busy[bus.i_wb_pipe_rd]) begin
            err <= 1'b1;
        end
    end

    assign bus.o_wb_lu_ready  = lu_ready;
    assign bus.o_wb_rf_we     = rf_we;
    assign bus.o_wb_rf_a3     = rf_a3;
    assign bus.o_wb_rf_wd3    = rf_wd3;
    assign bus.o_wb_busy_mask = busy;
    assign bus.o_wb_stall     = stall;
    assign bus.o_wb_err       = err;
endmodule

// File: tb/tb_core_wb_arb.sv
// Directed bench for core_wb_arb: queued long-latency results are tracked in a scoreboard queue.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
// Stall timing is supplied per step from hand-derived cycle counts.
module tb_core_wb_arb;
    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] dat;
    } ent_t;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    logic exp_err;
    ent_t sb[$];

    core_wb_arb_if bus ();

    core_wb_arb #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .i_wb_clk   (clk),
        .i_wb_rst_n (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic p_we, input logic [4:0] p_rd, input logic [63:0] p_dat,
                         input logic l_vld, input logic [4:0] l_rd, input logic [63:0] l_dat);
        bus.i_wb_pipe_we   = p_we;
        bus.i_wb_pipe_rd   = p_rd;
        bus.i_wb_pipe_data = p_dat;
        bus.i_wb_lu_valid  = l_vld;
        bus.i_wb_lu_rd     = l_rd;
        bus.i_wb_lu_data   = l_dat;
    endtask

    // One clock cycle: drive, check every output against the scoreboard, retire/enqueue, advance.
    task automatic step(input string tag,
                        input logic p_we, input logic [4:0] p_rd, input logic [63:0] p_dat,
                        input logic l_vld, input logic [4:0] l_rd, input logic [63:0] l_dat,
                        input logic x_stall);
        logic [31:0] x_mask;
        logic        x_ready;
        logic        x_pipe;
        logic        x_we;
        logic [4:0]  x_a3;
        logic [63:0] x_wd;
        drive(p_we, p_rd, p_dat, l_vld, l_rd, l_dat);
        #1;
        x_mask = 32'd0;
        foreach (sb[i]) x_mask[sb[i].rd] = 1'b1;
        x_ready = (sb.size() < 4);
        x_pipe  = p_we && (p_rd != 5'd0) && !x_stall;
        x_we = 1'b0; x_a3 = 5'd0; x_wd = 64'd0;
        if (x_pipe) begin
            x_we = 1'b1; x_a3 = p_rd; x_wd = p_dat;
        end else if (sb.size() > 0) begin
            x_we = 1'b1; x_a3 = sb[0].rd; x_wd = sb[0].dat;
        end
        chk({tag, " rf_we"},     64'(bus.o_wb_rf_we),     64'(x_we));
        chk({tag, " rf_a3"},     64'(bus.o_wb_rf_a3),     64'(x_a3));
        chk({tag, " rf_wd3"},    bus.o_wb_rf_wd3,         x_wd);
        chk({tag, " busy_mask"}, 64'(bus.o_wb_busy_mask), 64'(x_mask));
        chk({tag, " stall"},     64'(bus.o_wb_stall),     64'(x_stall));
        chk({tag, " lu_ready"},  64'(bus.o_wb_lu_ready),  64'(x_ready));
        chk({tag, " err"},       64'(bus.o_wb_err),       64'(exp_err));
        if (x_pipe && x_mask[p_rd]) exp_err = 1'b1;
        if (!x_pipe && sb.size() > 0) void'(sb.pop_front());
        if (l_vld && x_ready && l_rd != 5'd0) sb.push_back('{rd: l_rd, dat: l_dat});
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " rf_we"},     64'(bus.o_wb_rf_we),     64'd0);
        chk({tag, " rf_a3"},     64'(bus.o_wb_rf_a3),     64'd0);
        chk({tag, " rf_wd3"},    bus.o_wb_rf_wd3,         64'd0);
        chk({tag, " busy_mask"}, 64'(bus.o_wb_busy_mask), 64'd0);
        chk({tag, " stall"},     64'(bus.o_wb_stall),     64'd0);
        chk({tag, " lu_ready"},  64'(bus.o_wb_lu_ready),  64'd1);
        chk({tag, " err"},       64'(bus.o_wb_err),       64'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_err     = 1'b0;
        rst_n       = 1'b0;

        // Reset held with both sources active: nothing may reach the port or the FIFO.
        drive(1'b1, 5'd3, 64'h3333, 1'b1, 5'd6, 64'h6666);
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle("post_reset");

        // Single enqueue with the pipeline idle: written the next cycle, mask clears after.
        step("enq5", 1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 64'hAAAA, 1'b0);
        idle("drain5");
        idle("empty5");

        // Fill the FIFO while the pipeline hogs the port; the ninth cycle is the forced drain.
        for (int k = 0; k < 4; k++)
            step($sformatf("fill%0d", k), 1'b1, 5'd10, 64'hD000 + 64'(k),
                 1'b1, 5'(k + 1), 64'h1000 + 64'(k + 1), 1'b0);
        for (int k = 4; k < 9; k++)
            step($sformatf("starve%0d", k), 1'b1, 5'd10, 64'hD000 + 64'(k),
                 1'b0, 5'd0, 64'd0, 1'b0);
        step("stall", 1'b1, 5'd10, 64'hD009, 1'b0, 5'd0, 64'd0, 1'b1);
        step("resume", 1'b1, 5'd10, 64'hD00A, 1'b0, 5'd0, 64'd0, 1'b0);
        for (int k = 0; k < 4; k++) idle($sformatf("drainfill%0d", k));

        // Pipeline write to x0 is a free slot for the queued rd=7 result.
        step("enq7", 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'h7777, 1'b0);
        step("x0slot", 1'b1, 5'd0, 64'hBAD0, 1'b0, 5'd0, 64'd0, 1'b0);
        idle("after7");

        // Long-latency result to x0 completes but is not stored.
        step("enq0", 1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'h0F0F, 1'b0);
        idle("after0");

        // Pipeline overwrites a register still queued: write happens, error latches, head still drains.
        step("enq9", 1'b1, 5'd10, 64'hA10, 1'b1, 5'd9, 64'h9999, 1'b0);
        step("clash9", 1'b1, 5'd9, 64'hC9C9, 1'b0, 5'd0, 64'd0, 1'b0);
        idle("drain9");
        idle("sticky");

        // Reset in mid-operation discards queued results and clears the error.
        step("pre_rst_a", 1'b1, 5'd10, 64'hE1, 1'b1, 5'd11, 64'hB1, 1'b0);
        step("pre_rst_b", 1'b1, 5'd10, 64'hE2, 1'b1, 5'd12, 64'hB2, 1'b0);
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        sb.delete();
        exp_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle("post_midreset");
        step("enq_after", 1'b0, 5'd0, 64'd0, 1'b1, 5'd13, 64'hDD, 1'b0);
        idle("drain_after");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
